// File: rtl/clock_divider_multi.sv
// clock_divider_multi: N-channel programmable clock divider.
// Each channel produces a 50 % duty square wave (CLOCK_OUT) and a one-cycle
// tick on its rising edge. The half-period is runtime-programmable. A new
// value is staged and applied at the next wrap, so no half-period is ever
// cut short. A global SYNC strobe phase-aligns every channel.
module clock_divider_multi #(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 25
) (
  input  logic             CLOCK_50MHZ,
  input  logic             RESET,
  input  logic [N_CH-1:0]  ENABLE,
  input  logic             SYNC,
  input  logic             WR_EN,
  input  logic [3:0]       WR_ADDR,
  input  logic [CNT_W-1:0] WR_DATA,
  output logic [N_CH-1:0]  CLOCK_OUT,
  output logic [N_CH-1:0]  TICK,
  output logic [N_CH-1:0]  PENDING
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] act_q [N_CH];
  logic [CNT_W-1:0] pnd_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] act_d [N_CH];
  logic [CNT_W-1:0] pnd_d [N_CH];
  logic [N_CH-1:0]  clk_d;
  logic [N_CH-1:0]  tick_d;
  logic [N_CH-1:0]  pend_d;

  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  stopped;
  logic [N_CH-1:0]  wrap;

  // Per-channel write decode and run-state conditions.
  // An out-of-range WR_ADDR matches no channel and is dropped.
  always_comb begin
    wr_hit  = '0;
    stopped = '0;
    wrap    = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      wr_hit[ch]  = WR_EN && (WR_ADDR == 4'(ch));
      stopped[ch] = !ENABLE[ch] || (act_q[ch] == '0);
      wrap[ch]    = (cnt_q[ch] == act_q[ch] - CNT_W'(1));
    end
  end

  // Next-state for counter, half-period registers and outputs.
  // Priority: SYNC, then stopped/disabled, then wrap, then count.
  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      cnt_d[ch]  = cnt_q[ch];
      act_d[ch]  = act_q[ch];
      pnd_d[ch]  = pnd_q[ch];
      clk_d[ch]  = CLOCK_OUT[ch];
      tick_d[ch] = 1'b0;
      pend_d[ch] = PENDING[ch];

      if (SYNC) begin
        cnt_d[ch] = '0;
        clk_d[ch] = 1'b0;
        if (wr_hit[ch]) begin
          act_d[ch]  = WR_DATA;
          pnd_d[ch]  = WR_DATA;
          pend_d[ch] = 1'b0;
        end else if (PENDING[ch]) begin
          act_d[ch]  = pnd_q[ch];
          pend_d[ch] = 1'b0;
        end
      end else if (stopped[ch]) begin
        // Nothing is running, so a write can take effect at once.
        cnt_d[ch] = '0;
        clk_d[ch] = 1'b0;
        if (wr_hit[ch]) begin
          act_d[ch]  = WR_DATA;
          pnd_d[ch]  = WR_DATA;
          pend_d[ch] = 1'b0;
        end
      end else if (wrap[ch]) begin
        cnt_d[ch]  = '0;
        clk_d[ch]  = !CLOCK_OUT[ch];
        tick_d[ch] = !CLOCK_OUT[ch];
        // A write landing on the wrap itself goes straight into ACT.
        if (wr_hit[ch]) begin
          act_d[ch]  = WR_DATA;
          pnd_d[ch]  = WR_DATA;
          pend_d[ch] = 1'b0;
        end else if (PENDING[ch]) begin
          act_d[ch]  = pnd_q[ch];
          pend_d[ch] = 1'b0;
        end
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        if (wr_hit[ch]) begin
          pnd_d[ch]  = WR_DATA;
          pend_d[ch] = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50MHZ) begin
    if (RESET) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        cnt_q[ch] <= '0;
        act_q[ch] <= DEF_HALF;
        pnd_q[ch] <= DEF_HALF;
      end
      CLOCK_OUT <= '0;
      TICK      <= '0;
      PENDING   <= '0;
    end else begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
        act_q[ch] <= act_d[ch];
        pnd_q[ch] <= pnd_d[ch];
      end
      CLOCK_OUT <= clk_d;
      TICK      <= tick_d;
      PENDING   <= pend_d;
    end
  end

endmodule
